// File: rtl/data_mem_pkg.sv
// Shared definitions for the LSU data memory: funct3 encodings, FSM states,
// response-pipeline metadata and the access legality check.
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {
        CLEAR,
        READY
    } mem_state_t;

    // Per-request bookkeeping carried down the response pipeline.
    typedef struct packed {
        logic       valid;
        logic       err;
        logic       load;
        logic [2:0] funct3;
    } resp_meta_t;

    // Returns 1 when the access is misaligned for its size or its funct3 is
    // not a legal encoding for the direction and word width.
    function automatic logic access_err(
        input logic       is_write,
        input logic [2:0] funct3,
        input logic [2:0] offset,
        input logic       is_rv64
    );
        logic illegal;
        logic misaligned;
        if (is_write) begin
            illegal = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                        (is_rv64 && (funct3 == F3_D)));
        end else begin
            illegal = (funct3 == 3'b111) ||
                      (!is_rv64 && ((funct3 == F3_D) || (funct3 == F3_WU)));
        end
        case (funct3[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset[1:0];
            2'b11:   misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory. Store side turns a right-justified
// store into a byte-enable mask and lane-positioned write word; load side
// shifts the addressed field down and sign- or zero-extends it.
module mem_lane_align
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFFS       = 2
) (
    input  logic [1:0]              st_size,
    input  logic [OFFS-1:0]         st_lane,
    input  logic [DATA_WIDTH-1:0]   st_wdata,
    output logic [DATA_WIDTH/8-1:0] st_be,
    output logic [DATA_WIDTH-1:0]   st_wword,
    input  logic [DATA_WIDTH-1:0]   ld_word,
    input  logic [OFFS-1:0]         ld_lane,
    input  logic [2:0]              ld_funct3,
    output logic [DATA_WIDTH-1:0]   ld_result
);

    logic [DATA_WIDTH/8-1:0] base_be;
    logic [DATA_WIDTH-1:0]   shifted;

    // Store side: size-based mask at lane 0, then moved up to the addressed lane.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        base_be = '0;
        case (st_size)
            2'b00:   base_be[0]   = 1'b1;
            2'b01:   base_be[1:0] = 2'b11;
            2'b10:   base_be[3:0] = 4'hF;
            default: base_be      = '1;
        endcase
        st_be    = base_be << st_lane;
        st_wword = st_wdata << {st_lane, 3'b000};
    end

    // Load side: bring the addressed field to bit 0 and extend per funct3.
    always_comb begin
        shifted   = ld_word >> {ld_lane, 3'b000};
        ld_result = '0;
        case (ld_funct3)
            F3_B:    ld_result = DATA_WIDTH'($signed(shifted[7:0]));
            F3_H:    ld_result = DATA_WIDTH'($signed(shifted[15:0]));
            F3_W:    ld_result = DATA_WIDTH'($signed(shifted[31:0]));
            F3_D:    ld_result = shifted;
            F3_BU:   ld_result = DATA_WIDTH'(shifted[7:0]);
            F3_HU:   ld_result = DATA_WIDTH'(shifted[15:0]);
            F3_WU:   ld_result = DATA_WIDTH'(shifted[31:0]);
            default: ld_result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_data_mem.sv
// Single-port word-organised data memory for the MEM stage: byte-lane stores,
// extended loads, error reporting, optional post-reset clear and a fixed
// RD_LATENCY response pipeline.
module lsu_data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int OFFS  = $clog2(DATA_WIDTH / 8);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IW    = ADDR_WIDTH - OFFS;
    localparam int DEPTH = 2 ** IW;
    localparam int LAST  = RD_LATENCY - 1;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("lsu_data_mem: DATA_WIDTH must be 32 or 64");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
        $error("lsu_data_mem: RD_LATENCY must be 1..3");
    end

    mem_state_t state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;

    logic            accept;
    logic            req_err;
    logic [OFFS-1:0] lane;
    logic [IW-1:0]   word_idx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [NB-1:0]         st_be;
    logic [DATA_WIDTH-1:0] st_wword;
    logic [DATA_WIDTH-1:0] ld_result;

    resp_meta_t            meta_q [RD_LATENCY];
    resp_meta_t            meta_d [RD_LATENCY];
    logic [OFFS-1:0]       lane_q [RD_LATENCY];
    logic [OFFS-1:0]       lane_d [RD_LATENCY];
    logic [DATA_WIDTH-1:0] word_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] word_d [RD_LATENCY];

    assign lane      = req_addr[OFFS-1:0];
    assign word_idx  = req_addr[ADDR_WIDTH-1:OFFS];
    assign req_ready = (state_q == READY) && !reset;
    assign busy      = (state_q == CLEAR);
    assign accept    = req_valid && req_ready;
    assign req_err   = access_err(req_write, req_funct3, 3'(lane), DATA_WIDTH == 64);
    assign mem_rdata = mem[word_idx];

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFFS       (OFFS)
    ) u_align (
        .st_size   (req_funct3[1:0]),
        .st_lane   (lane),
        .st_wdata  (req_wdata),
        .st_be     (st_be),
        .st_wword  (st_wword),
        .ld_word   (word_q[LAST]),
        .ld_lane   (lane_q[LAST]),
        .ld_funct3 (meta_q[LAST].funct3),
        .ld_result (ld_result)
    );

    // Clear sequencer: walk every word once after reset, then serve requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + IW'(1);
                if (&cnt_q) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // FSM state and clear counter registers.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array: clear writes during CLEAR, byte-enabled stores when accepted.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset branch; contents are zeroed by the clear sequence instead, which keeps it mappable to SRAM.
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (accept && req_write && !req_err) begin
            for (int b = 0; b < NB; b++) begin
                if (st_be[b]) mem[word_idx][8*b +: 8] <= st_wword[8*b +: 8];
            end
        end
    end

    // Response pipeline next state: stage 0 captures the accepted request.
    always_comb begin
        meta_d[0] = '{valid: accept, err: accept && req_err,
                      load: accept && !req_write, funct3: req_funct3};
        lane_d[0] = lane;
        word_d[0] = (accept && !req_write) ? mem_rdata : '0;
        for (int k = 1; k < RD_LATENCY; k++) begin
            meta_d[k] = meta_q[k-1];
            lane_d[k] = lane_q[k-1];
            word_d[k] = word_q[k-1];
        end
    end

    // Response pipeline registers; reset drops everything in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                meta_q[k] <= '0;
                lane_q[k] <= '0;
                word_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                meta_q[k] <= meta_d[k];
                lane_q[k] <= lane_d[k];
                word_q[k] <= word_d[k];
            end
        end
    end

    // Response outputs: data only for error-free loads, zero otherwise.
    always_comb begin
        resp_valid = meta_q[LAST].valid;
        resp_err   = meta_q[LAST].valid && meta_q[LAST].err;
        resp_rdata = (meta_q[LAST].valid && meta_q[LAST].load && !meta_q[LAST].err)
                     ? ld_result : '0;
    end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Bench for lsu_data_mem: two instances (RD_LATENCY 1 and 3) share one request
// stream; a byte-array reference model predicts every response and the
// busy/ready timing, checked each cycle.
module tb_lsu_data_mem;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LD = 3'd3;
    localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, LWU = 3'd6;
    localparam int CLEAR_CYCLES = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;

    logic        ready1, rv1, err1, busy1;
    logic [31:0] rd1;
    logic        ready3, rv3, err3, busy3;
    logic [31:0] rd3;

    lsu_data_mem #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .resp_valid(rv1), .resp_rdata(rd1),
        .resp_err(err1), .busy(busy1));

    lsu_data_mem #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_LATENCY(3), .CLEAR_ON_RESET(1)) dut3 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .resp_valid(rv3), .resp_rdata(rd3),
        .resp_err(err3), .busy(busy3));

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t       q1[$];
    exp_t       q3[$];
    logic [7:0] ref_mem [4096];
    int         cyc        = 0;
    int         clear_left = CLEAR_CYCLES;
    int         checks     = 0;
    int         failures   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the access rules: byte-addressed memory,
    // size = 1 << funct3[1:0], signed unless funct3[2] is set.
    task automatic model(input bit w, input logic [11:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, output logic [31:0] d, output logic e);
        int nb;
        bit illegal;
        nb = 1 << f3[1:0];
        if (w) illegal = (f3 > 3'd2);
        else   illegal = (f3 == LD) || (f3 == LWU) || (f3 == 3'd7);
        d = '0;
        e = illegal || ((int'(a) % nb) != 0);
        if (e) return;
        if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) d[8*i +: 8] = ref_mem[int'(a) + i];
            if (!f3[2] && nb < 4 && d[8*nb-1]) d = d | (32'hFFFF_FFFF << (8*nb));
        end
    endtask

    // Present one request for one cycle; when lit is set, the literal
    // expectation replaces the model's prediction (the model still tracks stores).
    task automatic issue(input bit w, input logic [11:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, input bit lit = 1'b0,
                         input logic [31:0] lit_d = '0, input bit lit_e = 1'b0);
        exp_t        e;
        logic [31:0] md;
        logic        me;
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_funct3 = f3;
        req_wdata  = wd;
        if (!reset && clear_left == 0) begin
            model(w, a, f3, wd, md, me);
            e.data = lit ? lit_d : md;
            e.err  = lit ? lit_e : me;
            e.due  = cyc + 1;
            q1.push_back(e);
            e.due  = cyc + 3;
            q3.push_back(e);
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        reset     = 1'b1;
        req_valid = 1'b0;
        q1.delete();
        q3.delete();
        clear_left = CLEAR_CYCLES;
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        repeat (hold) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic mon(input int lat, input logic v, input logic [31:0] d, input logic e);
        exp_t head;
        bit   has;
        if (lat == 1) has = (q1.size() > 0) && (q1[0].due == cyc);
        else          has = (q3.size() > 0) && (q3[0].due == cyc);
        if (has) begin
            if (lat == 1) head = q1.pop_front();
            else          head = q3.pop_front();
        end else begin
            head.data = '0;
            head.err  = 1'b0;
        end
        check($sformatf("L%0d_resp_valid@%0d", lat, cyc), 32'(v), 32'(has));
        check($sformatf("L%0d_resp_rdata@%0d", lat, cyc), d, head.data);
        check($sformatf("L%0d_resp_err@%0d", lat, cyc), 32'(e), 32'(head.err));
    endtask

    // Per-cycle monitor, sampling 1 time unit after the rising edge.
    always @(posedge clock) begin
        cyc++;
        if (!reset && clear_left > 0) clear_left--;
        #1;
        check($sformatf("L1_busy@%0d", cyc), 32'(busy1), 32'(reset || clear_left > 0));
        check($sformatf("L3_busy@%0d", cyc), 32'(busy3), 32'(reset || clear_left > 0));
        check($sformatf("L1_ready@%0d", cyc), 32'(ready1), 32'(!reset && clear_left == 0));
        check($sformatf("L3_ready@%0d", cyc), 32'(ready3), 32'(!reset && clear_left == 0));
        mon(1, rv1, rd1, err1);
        mon(3, rv3, rd3, err3);
    end

    initial begin
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        do_reset(3);

        // Requests during the clear sequence are ignored.
        repeat (5) @(negedge clock);
        issue(1'b1, 12'h3FC, LW, 32'h1234_5678);
        issue(1'b0, 12'h3FC, LW, 32'h0);
        repeat (CLEAR_CYCLES) @(negedge clock);
        check("ready_after_clear", 32'(ready1 & ready3), 32'd1);
        issue(1'b0, 12'h3FC, LW, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 12'hFFC, LW, 32'h0, 1'b1, 32'h0);

        // Byte lanes.
        issue(1'b1, 12'h010, LW, 32'h1122_3344, 1'b1, 32'h0);
        issue(1'b1, 12'h012, LB, 32'hFFFF_FFAA, 1'b1, 32'h0);
        issue(1'b0, 12'h010, LW, 32'h0, 1'b1, 32'h11AA_3344);
        issue(1'b0, 12'h012, LB, 32'h0, 1'b1, 32'hFFFF_FFAA);
        issue(1'b0, 12'h012, LBU, 32'h0, 1'b1, 32'h0000_00AA);

        // Halfwords.
        issue(1'b1, 12'h022, LH, 32'h5555_8001, 1'b1, 32'h0);
        issue(1'b0, 12'h022, LH, 32'h0, 1'b1, 32'hFFFF_8001);
        issue(1'b0, 12'h022, LHU, 32'h0, 1'b1, 32'h0000_8001);
        issue(1'b0, 12'h020, LW, 32'h0, 1'b1, 32'h8001_0000);

        // Errors: misaligned store leaves memory alone; illegal encodings.
        issue(1'b1, 12'h013, LW, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 12'h010, LW, 32'h0, 1'b1, 32'h11AA_3344);
        issue(1'b0, 12'h021, LH, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 12'h010, 3'd7, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 12'h010, LD, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 12'h010, LWU, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b1, 12'h018, LD, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b1, 12'h018, LBU, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 12'h018, LW, 32'h0, 1'b1, 32'h0);

        // Back-to-back store then load of the same word.
        issue(1'b1, 12'h040, LW, 32'hDEAD_BEEF, 1'b1, 32'h0);
        issue(1'b0, 12'h040, LW, 32'h0, 1'b1, 32'hDEAD_BEEF);
        repeat (4) @(negedge clock);

        // Randomised traffic over a small window so words get reused.
        for (int n = 0; n < 400; n++) begin
            issue(1'($urandom_range(0, 1)), 12'h100 + 12'($urandom_range(0, 63)),
                  3'($urandom_range(0, 7)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        repeat (4) @(negedge clock);

        // Reset with two loads still in flight on the deeper pipeline.
        issue(1'b0, 12'h010, LW, 32'h0);
        issue(1'b0, 12'h040, LW, 32'h0);
        do_reset(3);
        repeat (CLEAR_CYCLES + 4) @(negedge clock);
        issue(1'b0, 12'h010, LW, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 12'h040, LW, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 12'h104, LW, 32'h0, 1'b1, 32'h0);

        repeat (6) @(negedge clock);
        check("drain_L1", q1.size(), 32'd0);
        check("drain_L3", q3.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
